// File: rtl/mem_copy_engine_pkg.sv
// Shared constants and FSM encoding for the doubleword memory copy engine.
package mem_copy_engine_pkg;

  localparam int MEM_BYTES  = 256;
  localparam int WORD_BYTES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Data-memory bus between the copy engine (master) and the memory (slave).
interface mem_copy_engine_if;
  import mem_copy_engine_pkg::*;

  logic [63:0] Mem_Addr;
  logic [63:0] Write_Data;
  logic [63:0] Read_Data;
  logic        MemRead;
  logic        MemWrite;

  modport master (
    output Mem_Addr, Write_Data, MemRead, MemWrite,
    input  Read_Data
  );

  modport slave (
    input  Mem_Addr, Write_Data, MemRead, MemWrite,
    output Read_Data
  );

endinterface

// File: rtl/mem_copy_engine_range_check.sv
// Combinational alignment and bounds check of one copy region.
module mem_range_check #(
  parameter int MEM_BYTES  = mem_copy_engine_pkg::MEM_BYTES,
  parameter int WORD_BYTES = mem_copy_engine_pkg::WORD_BYTES
) (
  input  logic [63:0] addr,
  input  logic [5:0]  count,
  output logic        ok
);
  import mem_copy_engine_pkg::*;

  logic [64:0] end_addr;

  // One extra bit so a region near the top of the address space cannot wrap to a small end.
  assign end_addr = {1'b0, addr} + 65'(count) * 65'(WORD_BYTES);
  assign ok       = ((addr % 64'(WORD_BYTES)) == 64'd0) && (end_addr <= 65'(MEM_BYTES));

endmodule

// File: rtl/mem_copy_engine.sv
// Copies count doublewords from src_addr to dst_addr, one READ/WRITE pair per word.
module mem_copy_engine #(
  parameter int MEM_BYTES  = mem_copy_engine_pkg::MEM_BYTES,
  parameter int WORD_BYTES = mem_copy_engine_pkg::WORD_BYTES
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [63:0]               src_addr,
  input  logic [63:0]               dst_addr,
  input  logic [5:0]                count,
  mem_copy_engine_if.master         mem,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);
  import mem_copy_engine_pkg::*;

  state_t      state, state_nxt;
  logic [63:0] src_ptr, dst_ptr, data_q;
  logic [5:0]  rem_q;
  logic        err_q;
  logic        src_ok, dst_ok, accept, req_ok;

  mem_range_check #(.MEM_BYTES(MEM_BYTES), .WORD_BYTES(WORD_BYTES)) u_src_check (
    .addr (src_addr),
    .count(count),
    .ok   (src_ok)
  );

  mem_range_check #(.MEM_BYTES(MEM_BYTES), .WORD_BYTES(WORD_BYTES)) u_dst_check (
    .addr (dst_addr),
    .count(count),
    .ok   (dst_ok)
  );

  assign accept = (state == IDLE) && start;
  assign req_ok = src_ok && dst_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (!req_ok || count == 6'd0) ? DONE : READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (rem_q == 6'd1) ? DONE : READ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      src_ptr <= src_addr;
      dst_ptr <= dst_addr;
      rem_q   <= count;
      err_q   <= !req_ok;
    end else if (state == READ) begin
      data_q  <= mem.Read_Data;
      src_ptr <= src_ptr + 64'(WORD_BYTES);
    end else if (state == WRITE) begin
      dst_ptr <= dst_ptr + 64'(WORD_BYTES);
      rem_q   <= rem_q - 6'd1;
    end
  end

  // The bus is fully zeroed whenever no transfer is in flight.
  always_comb begin
    mem.MemRead    = 1'b0;
    mem.MemWrite   = 1'b0;
    mem.Mem_Addr   = '0;
    mem.Write_Data = '0;
    done           = 1'b0;
    case (state)
      READ: begin
        mem.MemRead  = 1'b1;
        mem.Mem_Addr = src_ptr;
      end
      WRITE: begin
        mem.MemWrite   = 1'b1;
        mem.Mem_Addr   = dst_ptr;
        mem.Write_Data = data_q;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a word-array copy model.
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [63:0] src_addr, dst_addr;
  logic [5:0]  count;
  logic        busy, done, err;

  logic [63:0] mem_dw  [32];
  logic [63:0] ref_mem [32];
  int          checks = 0;
  int          errors = 0;

  mem_copy_engine_if bus ();

  mem_copy_engine #(.MEM_BYTES(256), .WORD_BYTES(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .count   (count),
    .mem     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  assign bus.Read_Data = mem_dw[bus.Mem_Addr[7:3]];

  always @(posedge clk) begin
    if (bus.MemWrite) mem_dw[bus.Mem_Addr[7:3]] = bus.Write_Data;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic init_mem(input bit rnd);
    logic [63:0] v;
    for (int i = 0; i < 32; i++) begin
      if (rnd) v = {$urandom, $urandom};
      else begin
        case (i)
          0:       v = 64'd3;
          1:       v = 64'd1;
          2:       v = 64'd4;
          3:       v = 64'd2;
          default: v = 64'd0;
        endcase
      end
      mem_dw[i]  = v;
      ref_mem[i] = v;
    end
  endtask

  // A request is legal when both regions are word aligned and fit in 256 bytes.
  function automatic bit req_legal(input logic [63:0] s, input logic [63:0] d, input int n);
    logic [64:0] s_end, d_end;
    s_end = {1'b0, s} + 65'(8 * n);
    d_end = {1'b0, d} + 65'(8 * n);
    return (s[2:0] == 3'd0) && (d[2:0] == 3'd0) && (s_end <= 65'd256) && (d_end <= 65'd256);
  endfunction

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) chk(tag, mem_dw[i], ref_mem[i]);
  endtask

  task automatic run_req(input logic [63:0] s, input logic [63:0] d, input int n_req, input bit hold);
    bit          ok;
    int          n, wi;
    logic        e_rd, e_wr, e_dn, e_bs;
    logic [63:0] e_addr, e_wd;
    @(negedge clk);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    count    = 6'(n_req);
    ok = req_legal(s, d, n_req);
    n  = ok ? n_req : 0;
    @(posedge clk);
    for (int k = 1; k <= 2 * n + 2; k++) begin
      @(negedge clk);
      e_rd = 1'b0; e_wr = 1'b0; e_dn = 1'b0; e_addr = '0; e_wd = '0;
      e_bs = (k <= 2 * n + 1);
      if (k <= 2 * n) begin
        if (k % 2 == 1) begin
          e_rd   = 1'b1;
          e_addr = s + 64'(8 * ((k - 1) / 2));
        end else begin
          wi     = k / 2 - 1;
          e_wr   = 1'b1;
          e_addr = d + 64'(8 * wi);
          e_wd   = ref_mem[int'(s >> 3) + wi];
          ref_mem[int'(d >> 3) + wi] = e_wd;
        end
      end else if (k == 2 * n + 1) begin
        e_dn = 1'b1;
      end
      chk("ctl rd/wr/done/busy/err", {bus.MemRead, bus.MemWrite, done, busy, err},
          {e_rd, e_wr, e_dn, e_bs, !ok});
      chk("mem_addr", bus.Mem_Addr, e_addr);
      chk("write_data", bus.Write_Data, e_wd);
      if (hold) begin
        start    = (k < 2 * n + 1);
        src_addr = 64'(8 * $urandom_range(0, 31));
        dst_addr = 64'(8 * $urandom_range(0, 31));
        count    = 6'($urandom_range(1, 4));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_mem("mem_contents");
  endtask

  initial begin
    logic [63:0] rs, rd;
    int          rn;
    reset_n  = 1'b0;
    start    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    count    = '0;
    init_mem(1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ctl", {bus.MemRead, bus.MemWrite, done, busy, err}, 64'd0);
    chk("reset addr", bus.Mem_Addr, 64'd0);
    chk("reset wdata", bus.Write_Data, 64'd0);
    reset_n = 1'b1;

    // Basic copy of four preloaded words.
    run_req(64'd0, 64'd64, 4, 1'b0);
    chk("copy dw64", mem_dw[8], 64'd3);
    chk("copy dw72", mem_dw[9], 64'd1);
    chk("copy dw80", mem_dw[10], 64'd4);
    chk("copy dw88", mem_dw[11], 64'd2);

    init_mem(1'b0);
    run_req(64'd0, 64'd64, 0, 1'b0);
    run_req(64'd4, 64'd64, 1, 1'b0);
    run_req(64'd0, 64'd248, 2, 1'b0);
    run_req(64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1, 1'b0);
    run_req(64'd0, 64'd8, 4, 1'b0);

    // start held with changing addresses during the copy must be ignored.
    init_mem(1'b0);
    run_req(64'd0, 64'd64, 4, 1'b1);
    chk("hold dw64", mem_dw[8], 64'd3);
    chk("hold dw88", mem_dw[11], 64'd2);

    // Reset in cycle 3: one word written, second not yet.
    init_mem(1'b0);
    @(negedge clk);
    start = 1'b1; src_addr = 64'd0; dst_addr = 64'd64; count = 6'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset ctl", {bus.MemRead, bus.MemWrite, done, busy, err}, 64'd0);
    chk("midreset addr", bus.Mem_Addr, 64'd0);
    chk("midreset wdata", bus.Write_Data, 64'd0);
    chk("midreset dw64", mem_dw[8], 64'd3);
    chk("midreset dw72", mem_dw[9], 64'd0);
    ref_mem[8] = ref_mem[0];
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_req(64'd0, 64'd64, 4, 1'b0);

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 2) == 0) init_mem(1'b1);
      if ($urandom_range(0, 5) == 0) rs = 64'($urandom_range(0, 255));
      else                           rs = 64'(8 * $urandom_range(0, 31));
      if ($urandom_range(0, 5) == 0) rd = 64'($urandom_range(0, 255));
      else                           rd = 64'(8 * $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) rn = $urandom_range(0, 32);
      else                           rn = $urandom_range(0, 32 - int'(((rs > rd) ? rs : rd) >> 3));
      run_req(rs, rd, rn, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter MEM_BYTES, default 256: byte size of the attached data memory.
REQ-002 Parameter WORD_BYTES, default 8: bytes per transfer (one doubleword).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src_addr  input  64  byte address of the first source doubleword.
REQ-007 dst_addr  input  64  byte address of the first destination doubleword.
REQ-008 count  input  6  number of doublewords to copy, 0..32.
REQ-009 Read_Data  input  64  combinational read data returned by the data memory.
REQ-010 Mem_Addr  output  64  byte address driven to the data memory.
REQ-011 Write_Data  output  64  store data driven to the data memory, little-endian doubleword.
REQ-012 MemRead  output  1  memory read strobe.
REQ-013 MemWrite  output  1  memory write strobe; the memory commits on the rising clk edge while high.
REQ-014 busy  output  1  high from the accept edge until the cycle after done.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 err  output  1  request rejected; sticky until the next accepted start.

Function
REQ-017 The FSM SHALL have the states IDLE, READ, WRITE and DONE.
REQ-018 In IDLE with start=1, the engine SHALL latch src_addr, dst_addr and count into internal pointers and a remaining-count register, and clear err.
REQ-019 At acceptance, the engine SHALL reject the request if either address is not a multiple of WORD_BYTES, or if src_addr+8*count > MEM_BYTES or dst_addr+8*count > MEM_BYTES.
  - The check uses 65-bit arithmetic, with no wrap-around.
  - On rejection: set err=1 and go to DONE with no memory access.
REQ-020 An accepted request with count=0 SHALL go directly to DONE with no memory access and err=0.
REQ-021 In READ:
  - drive MemRead=1, MemWrite=0, Mem_Addr=src pointer;
  - capture Read_Data into a data register at the edge;
  - advance the src pointer by 8;
  - go to WRITE.
REQ-022 In WRITE:
  - drive MemWrite=1, MemRead=0, Mem_Addr=dst pointer, Write_Data=data register;
  - advance the dst pointer by 8 and decrement the remaining count;
  - go to READ if the remaining count stays nonzero, else DONE.
REQ-023 In DONE, the engine SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-024 Latency: with the accept edge as cycle 0, READ/WRITE SHALL alternate in cycles 1..2N, and done SHALL be high in cycle 2N+1 (cycle 1 for N=0 or rejection).
REQ-025 MemRead and MemWrite SHALL never be high in the same cycle.
REQ-026 Outside READ/WRITE, MemRead, MemWrite, Mem_Addr and Write_Data SHALL all be 0.
REQ-027 start SHALL be ignored in READ, WRITE and DONE; no queuing.
REQ-028 Copy order SHALL be ascending addresses.
  - Overlapping regions with dst > src yield forward-copy (replicating) results.
  - This is the defined behaviour, not an error.

Reset
REQ-029 reset_n low SHALL immediately force:
  - IDLE;
  - MemRead=0, MemWrite=0;
  - Mem_Addr=0, Write_Data=0;
  - busy=0, done=0, err=0;
  - pointers, count and data register cleared.
  This applies also mid-copy; writes already committed remain.
REQ-030 The first accept SHALL be possible on the first rising edge after reset_n deasserts.

Structure
REQ-031 A shared package SHALL hold MEM_BYTES, WORD_BYTES and the FSM state encoding (2 bits: IDLE=0, READ=1, WRITE=2, DONE=3).
REQ-032 The alignment/range check SHALL be a combinational sub-module mem_range_check (inputs: addr, count; output: ok), instantiated once each for src and dst.

Verification
The bench uses a behavioural 256-byte memory preloaded with doublewords 3, 1, 4, 2 at addresses 0, 8, 16, 24.
REQ-033 Copy (src=0, dst=64, count=4):
  - memory doublewords at 64/72/80/88 read 3/1/4/2;
  - MemRead/MemWrite alternate in cycles 1..8;
  - done pulses in cycle 9 with err=0.
REQ-034 count=0 (src=0, dst=64):
  - done in cycle 1, err=0;
  - MemRead and MemWrite stay 0.
REQ-035 Misaligned src=4 (count=1), and separately dst=248 with count=2 (range overflow):
  - err=1 and done in cycle 1;
  - no strobe asserted; memory unchanged.
REQ-036 reset_n pulsed low during cycle 3 of the REQ-033 copy:
  - all outputs 0 immediately;
  - only doubleword 64 holds 3; 72 is still 0.
REQ-037 start re-asserted with different addresses during cycles 1..9 of the REQ-033 copy:
  - ignored; REQ-033 results unchanged;
  - busy drops in cycle 10.
